// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: widths, FSM states and
// the queue entry that pairs an instruction with its PC.
package fetch_pkg;

   localparam int XLEN = 64;
   localparam int ILEN = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_RSP,
      DROP
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;

   // Branch targets are word aligned; the low two bits are simply cleared.
   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
      return {pc[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {pc, instr} entries toward decode.
// The caller guarantees no push when full and no pop when empty.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  fetch_entry_t                   entry,
   input  logic                           pop,
   input  logic                           flush,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output fetch_entry_t                   head
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t    r_mem [DEPTH];
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_wr_ptr;
   logic [CW-1:0]   r_count;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: storage is reset (it is tiny) so the head reads zero out of reset.
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) begin
            r_mem[r_wr_ptr] <= entry;
            r_wr_ptr        <= next_ptr(r_wr_ptr);
         end
         if (pop) r_rd_ptr <= next_ptr(r_rd_ptr);
         case ({push, pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign count = r_count;
   assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch front end: one outstanding memory read at a time, results queued
// toward decode, redirects flush the queue and discard in-flight responses.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_req_addr,
   input  logic            mem_rsp_valid,
   input  logic [ILEN-1:0] mem_rsp_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [ILEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc
);

   localparam int CW = $clog2(DEPTH + 1);

   fetch_state_t    r_state;
   logic [XLEN-1:0] r_fpc;
   logic [XLEN-1:0] r_req_pc;

   logic [CW-1:0]   w_count;
   fetch_entry_t    w_head;
   fetch_entry_t    w_push_entry;
   logic            w_req_fire;
   logic            w_push;
   logic            w_pop;

   // Request depends only on registered state so it never races the redirect.
   assign mem_req_valid = (r_state == IDLE) && (w_count < CW'(DEPTH));
   assign mem_req_addr  = r_fpc;
   assign w_req_fire    = mem_req_valid && mem_req_ready;

   assign w_push       = !redirect_valid && (r_state == WAIT_RSP) && mem_rsp_valid;
   assign w_pop        = !redirect_valid && out_valid && out_ready;
   assign w_push_entry = '{pc: r_req_pc, instr: mem_rsp_data};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_fpc    <= RESET_PC;
         r_req_pc <= '0;
      end else if (redirect_valid) begin
         r_fpc <= align_pc(redirect_pc);
         // An accepted-but-unanswered read must still be drained, so DROP.
         case (r_state)
            IDLE:    r_state <= w_req_fire ? DROP : IDLE;
            default: r_state <= mem_rsp_valid ? IDLE : DROP;
         endcase
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req_fire) begin
                  r_req_pc <= r_fpc;
                  r_fpc    <= r_fpc + XLEN'(4);
                  r_state  <= WAIT_RSP;
               end
            end
            WAIT_RSP: if (mem_rsp_valid) r_state <= IDLE;
            DROP:     if (mem_rsp_valid) r_state <= IDLE;
            default:  r_state <= IDLE;
         endcase
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .entry (w_push_entry),
      .pop   (w_pop),
      .flush (redirect_valid),
      .count (w_count),
      .head  (w_head)
   );

   assign out_valid = (w_count != '0);
   assign out_instr = w_head.instr;
   assign out_pc    = w_head.pc;

endmodule
